// File: rtl/bus_rr_arbiter_pkg.sv
// Shared types and constants for the four-requester round-robin bus arbiter.
// Imported by the interface, the pick logic and the arbiter top.
package arb_pkg;

   localparam int NUM_REQ = 4;
   localparam int SEL_W   = 2;
   localparam int CNT_W   = 8;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   // Encoded requester index to one-hot grant vector.
   function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
      logic [NUM_REQ-1:0] vec;
      vec      = {NUM_REQ{1'b0}};
      vec[idx] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/bus_rr_arbiter_if.sv
// Requester/slave-side handshake bundle of the round-robin arbiter.
// The arbiter uses the slave modport; the requester side uses master.
interface bus_rr_arbiter_if;
   import arb_pkg::*;

   logic [NUM_REQ-1:0] req;
   logic               done;
   logic [SEL_W-1:0]   sel;
   logic [NUM_REQ-1:0] gnt;
   logic               bus_en;
   logic               timeout;

   modport master (
      output req,
      output done,
      input  sel,
      input  gnt,
      input  bus_en,
      input  timeout
   );

   modport slave (
      input  req,
      input  done,
      output sel,
      output gnt,
      output bus_en,
      output timeout
   );

endinterface

// File: rtl/bus_rr_arbiter_rr_pick.sv
// Combinational round-robin winner selection: rotate the request vector so
// the slot after the last owner sits at bit 0, priority-encode, un-rotate.
module rr_pick
   import arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   last,
   output logic [SEL_W-1:0]   idx,
   output logic               any
);

   logic [SEL_W-1:0]   start_s;
   logic [NUM_REQ-1:0] rot_s;
   logic [SEL_W-1:0]   off_s;

   assign start_s = last + 2'd1;

   // Rotate requests so bit j is requester (last + 1 + j) mod 4.
   always_comb begin
      rot_s = {NUM_REQ{1'b0}};
      for (int j = 0; j < NUM_REQ; j++) begin
         rot_s[j] = req[start_s + SEL_W'(j)];
      end
   end

   // Priority-encode the rotated vector, lowest offset first.
   always_comb begin
      off_s = 2'd0;
      casez (rot_s)
         4'b???1: off_s = 2'd0;
         4'b??10: off_s = 2'd1;
         4'b?100: off_s = 2'd2;
         4'b1000: off_s = 2'd3;
         default: off_s = 2'd0;
      endcase
   end

   assign any = |rot_s;
   assign idx = start_s + off_s;

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter for the shared 32-bit 4:1 bus mux: holds one owner
// until done, owner withdrawal or watchdog expiry; all outputs registered.
module bus_rr_arbiter
   import arb_pkg::*;
#(
   parameter int TIMEOUT = 15   // owned cycles per grant, 1..255
)
(
   input  logic             clk,
   input  logic             reset,
   bus_rr_arbiter_if.slave  bus
);

   localparam logic [0:0]       ST_IDLE  = IDLE;
   localparam logic [0:0]       ST_BUSY  = BUSY;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [0:0]         state_r,   state_s;
   logic [SEL_W-1:0]   last_r,    last_s;
   logic [CNT_W-1:0]   cnt_r,     cnt_s;
   logic [SEL_W-1:0]   sel_r,     sel_s;
   logic [NUM_REQ-1:0] gnt_r,     gnt_s;
   logic               bus_en_r,  bus_en_s;
   logic               timeout_r, timeout_s;

   logic [SEL_W-1:0]   pick_idx_s;
   logic               pick_any_s;
   logic               owner_req_s;
   logic               release_s;
   logic               expire_s;

   rr_pick u_pick (
      .req  (bus.req),
      .last (last_r),
      .idx  (pick_idx_s),
      .any  (pick_any_s)
   );

   // In BUSY sel_r is the owner, so its request bit tells us if it withdrew.
   assign owner_req_s = bus.req[sel_r];
   assign release_s   = bus.done | ~owner_req_s;
   assign expire_s    = (cnt_r == CNT_LAST);

   // Next-state and next-output computation for the ownership FSM.
   always_comb begin
      state_s   = state_r;
      last_s    = last_r;
      cnt_s     = cnt_r;
      sel_s     = sel_r;
      gnt_s     = gnt_r;
      bus_en_s  = bus_en_r;
      timeout_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (pick_any_s) begin
               state_s  = ST_BUSY;
               sel_s    = pick_idx_s;
               last_s   = pick_idx_s;
               gnt_s    = onehot(pick_idx_s);
               bus_en_s = 1'b1;
               cnt_s    = {CNT_W{1'b0}};
            end else begin
               gnt_s    = {NUM_REQ{1'b0}};
               bus_en_s = 1'b0;
            end
         end
         ST_BUSY: begin
            // done has priority over withdrawal and watchdog, so no pulse then
            if (release_s) begin
               state_s  = ST_IDLE;
               gnt_s    = {NUM_REQ{1'b0}};
               bus_en_s = 1'b0;
               cnt_s    = {CNT_W{1'b0}};
            end else if (expire_s) begin
               state_s   = ST_IDLE;
               gnt_s     = {NUM_REQ{1'b0}};
               bus_en_s  = 1'b0;
               cnt_s     = {CNT_W{1'b0}};
               timeout_s = 1'b1;
            end else begin
               cnt_s = cnt_r + 8'd1;
            end
         end
         default: begin
            state_s  = ST_IDLE;
            gnt_s    = {NUM_REQ{1'b0}};
            bus_en_s = 1'b0;
            cnt_s    = {CNT_W{1'b0}};
         end
      endcase
   end

   // State and output registers; reset leaves requester 0 first in line.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         last_r    <= 2'd3;
         cnt_r     <= {CNT_W{1'b0}};
         sel_r     <= 2'd0;
         gnt_r     <= {NUM_REQ{1'b0}};
         bus_en_r  <= 1'b0;
         timeout_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         last_r    <= last_s;
         cnt_r     <= cnt_s;
         sel_r     <= sel_s;
         gnt_r     <= gnt_s;
         bus_en_r  <= bus_en_s;
         timeout_r <= timeout_s;
      end
   end

   assign bus.sel     = sel_r;
   assign bus.gnt     = gnt_r;
   assign bus.bus_en  = bus_en_r;
   assign bus.timeout = timeout_r;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Scoreboard bench for bus_rr_arbiter: directed scenarios then random traffic,
// expected outputs from an ownership-level reference model.
module tb_bus_rr_arbiter;
   import arb_pkg::*;

   localparam int TO = 5;

   typedef struct packed {
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       bus_en;
      logic       timeout;
   } exp_t;

   logic clk;
   logic reset;

   bus_rr_arbiter_if bus ();

   bus_rr_arbiter #(.TIMEOUT(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   // Reference model: who owns the bus, for how many cycles so far.
   int   m_owner = -1;
   int   m_last  = 3;
   int   m_held  = 0;
   int   m_sel   = 0;
   bit   m_to    = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic model_step(input logic [3:0] r, input bit d, input bit rs);
      exp_t e;
      int   w;
      int   c;
      if (rs) begin
         m_owner = -1; m_sel = 0; m_last = 3; m_held = 0; m_to = 1'b0;
      end else if (m_owner < 0) begin
         m_to = 1'b0;
         w = -1;
         for (int k = 1; k <= 4; k++) begin
            c = (m_last + k) % 4;
            if (w < 0 && r[c]) w = c;
         end
         if (w >= 0) begin
            m_owner = w; m_sel = w; m_last = w; m_held = 1;
         end
      end else if (d || !r[m_owner]) begin
         m_owner = -1; m_to = 1'b0;
      end else if (m_held == TO) begin
         m_owner = -1; m_to = 1'b1;
      end else begin
         m_held++; m_to = 1'b0;
      end
      e.gnt     = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
      e.sel     = 2'(m_sel);
      e.bus_en  = (m_owner >= 0);
      e.timeout = m_to;
      exp_q.push_back(e);
   endtask

   task automatic cyc(input logic [3:0] r, input bit d, input bit rs);
      @(negedge clk);
      bus.req  = r;
      bus.done = d;
      reset    = rs;
      model_step(r, d, rs);
   endtask

   // Monitor: one expected entry per clock once stimulus has started.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if ({bus.gnt, bus.sel, bus.bus_en, bus.timeout} !== mon_e) begin
               errors++;
               $display("FAIL outputs t=%0t got gnt=%b sel=%0d bus_en=%b timeout=%b required gnt=%b sel=%0d bus_en=%b timeout=%b",
                        $time, bus.gnt, bus.sel, bus.bus_en, bus.timeout,
                        mon_e.gnt, mon_e.sel, mon_e.bus_en, mon_e.timeout);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL time_limit t=%0t simulation did not finish", $time);
      $fatal(1, "time limit");
   end

   initial begin
      logic [3:0] rr;
      bit         dd;
      bit         rs;
      bus.req  = 4'b0000;
      bus.done = 1'b0;
      reset    = 1'b1;

      // Reset with everyone requesting, then first grant goes to 0
      cyc(4'b1111, 1'b0, 1'b1);
      cyc(4'b1111, 1'b0, 1'b1);
      cyc(4'b1111, 1'b0, 1'b0);
      cyc(4'b1111, 1'b1, 1'b0);
      cyc(4'b0000, 1'b0, 1'b0);

      // Single requester 2 with done on its third owned cycle
      repeat (3) cyc(4'b0100, 1'b0, 1'b0);
      cyc(4'b0100, 1'b1, 1'b0);
      cyc(4'b0000, 1'b0, 1'b0);
      cyc(4'b0000, 1'b0, 1'b1);

      // Fairness: all requesting, done every cycle
      repeat (10) cyc(4'b1111, 1'b1, 1'b0);
      cyc(4'b0000, 1'b0, 1'b0);
      cyc(4'b0000, 1'b0, 1'b1);

      // Watchdog revocation then handover to requester 1
      repeat (TO + 4) cyc(4'b0011, 1'b0, 1'b0);
      cyc(4'b0000, 1'b0, 1'b0);

      // Owner 1 withdraws, then stray done while idle
      repeat (3) cyc(4'b0010, 1'b0, 1'b0);
      cyc(4'b0000, 1'b0, 1'b0);
      cyc(4'b0000, 1'b1, 1'b0);
      cyc(4'b0000, 1'b1, 1'b0);

      // done and withdrawal in the same cycle
      repeat (2) cyc(4'b0001, 1'b0, 1'b0);
      cyc(4'b0000, 1'b1, 1'b0);

      // Reset mid-BUSY with requester 2 at count 3, then 0 wins over 2
      repeat (4) cyc(4'b0100, 1'b0, 1'b0);
      cyc(4'b0100, 1'b0, 1'b1);
      cyc(4'b0101, 1'b0, 1'b0);
      cyc(4'b0101, 1'b1, 1'b0);
      cyc(4'b0000, 1'b0, 1'b0);

      // Random traffic with sticky requests so timeouts also occur
      rr = 4'b1111;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) rr = 4'($urandom_range(0, 15));
         dd = ($urandom_range(0, 7) == 0);
         rs = ($urandom_range(0, 199) == 0);
         cyc(rr, dd, rs);
      end
      cyc(4'b0000, 1'b0, 1'b0);

      repeat (2) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending entries required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_rr_arbiter.md
# bus_rr_arbiter

Round-robin arbiter that shares the 32-bit 4-to-1 datapath multiplexer among four requesters (e.g. fetch, load/store, DMA, debug) in front of a single slave port. It registers the winning requester, drives the mux select and a one-hot grant, and holds ownership until the slave signals completion, the owner withdraws, or a watchdog timeout expires. The block is purely control; the 32-bit data path stays in the existing 4-to-1 mux, whose `S` input is driven by `sel`.

## Interface
- `TIMEOUT`, 15: maximum owned cycles per grant, legal range 1..255.
- `clk` input 1: single clock, all state updates on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `req` input 4: request per requester; bit i means requester i wants the bus.
- `done` input 1: slave completion for the current transfer; ignored unless in BUSY.
- `sel` output 2: registered mux select, the encoded index of the current or most recent owner.
- `gnt` output 4: registered one-hot grant; all zero when no owner.
- `bus_en` output 1: high exactly while in BUSY (equals `|gnt`).
- `timeout` output 1: one-cycle registered pulse when a grant is revoked by the watchdog.

## Operation
- States: IDLE, BUSY.
- Round-robin pointer `last` (2 bits) holds the index of the most recent owner. Search order is `last+1, last+2, last+3, last` (mod 4), and the first set `req` bit wins.
- IDLE, any `req` set: the winner is registered. Next cycle `gnt`=onehot(winner), `sel`=winner, `bus_en`=1, `last`=winner, watchdog count=0, state=BUSY.
- IDLE, `req`=0: stay in IDLE. `sel` holds its value so the mux output stays stable, and `gnt`=0.
- BUSY, `done`=1: release. Next cycle `gnt`=0, `bus_en`=0, state=IDLE.
- BUSY, owner's `req` bit =0 and `done`=0: abort release, same as `done` with no timeout pulse.
- BUSY, `done` and owner `req` drop in the same cycle: treated as `done`.
- BUSY, count==TIMEOUT-1, no `done`, `req` still held: revoke. Next cycle `gnt`=0, `timeout`=1, state=IDLE.
- BUSY, otherwise: count+1. Count is 8 bits unsigned and cannot wrap, because revocation occurs first.
- `req` changes on non-owner bits during BUSY have no effect until the next IDLE cycle.
- `done` while in IDLE: ignored.
- `reset` (any state, including mid-BUSY): next cycle state=IDLE, `gnt`=0, `sel`=0, `bus_en`=0, `timeout`=0, count=0, `last`=3, so requester 0 has top priority first.

## Timing
- Grant latency is 1 cycle: `req` sampled in an IDLE cycle t gives the grant at t+1.
- Release latency is 1 cycle: `done` at cycle k gives `gnt`=0 at k+1, and the earliest new grant is at k+2. There is one mandatory bubble between owners.
- Timeout: `bus_en` stays high for exactly TIMEOUT cycles, then `timeout`=1 in the following cycle, coincident with `gnt`=0.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Fairness: with all four requesting continuously, each requester is granted once per four grants.

## Structure
- Shared package `arb_pkg` holds:
  - state enum {IDLE, BUSY};
  - `NUM_REQ`=4;
  - `SEL_W`=2;
  - `CNT_W`=8.
- Sub-module `rr_pick`: combinational; inputs `req[3:0]` and `last[1:0]`, outputs `idx[1:0]` and `any`. It implements the rotate, priority-encode and un-rotate logic.
- The top level holds the FSM, the pointer, the watchdog counter and the output registers.

## Test plan
- Reset: assert `reset` for 2 cycles with `req`=4'b1111. Required: `gnt`=0, `sel`=0, `bus_en`=0, `timeout`=0. First grant after release of reset is `gnt`=4'b0001.
- Single requester: `req`=4'b0100 at cycle 0, `done` at cycle 3. Required: `gnt`=4'b0100 and `sel`=2 during cycles 1–3, `gnt`=0 at cycle 4.
- Fairness: `req`=4'b1111 held, `done` on every BUSY cycle. Required: grants are 0,1,2,3,0 at cycles 1,3,5,7,9.
- Watchdog, TIMEOUT=4: `req`=4'b0011 held, no `done`. Required: `gnt`=4'b0001 for cycles 1–4, `timeout`=1 at cycle 5, then `gnt`=4'b0010 at cycle 6.
- Abort and stray done: owner 1 drops `req` mid-BUSY. Required: `gnt`=0 next cycle with `timeout`=0. A `done` pulse while IDLE causes no state change.
- Reset mid-BUSY: requester 2 is owner at count 3 and `reset` is pulsed. Required: all outputs 0 next cycle. With `req`=4'b0101, the next grant goes to requester 0.
